// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between four byte requesters.
// Each frame is granted, started, then closed by finish or timeout, followed by a guard gap.
module uart_tx_arbiter #(
   parameter int clksPerBit  = 87,
   parameter int guardBits   = 1,
   parameter int timeoutClks = 2048
) (
   input  logic        i_clkTx,
   input  logic        i_rstN,
   input  logic [3:0]  i_req,
   input  logic [31:0] i_reqData,
   output logic [3:0]  o_grant,
   output logic        o_txStart,
   output logic [7:0]  o_txBits,
   input  logic        i_txBusy,
   input  logic        i_txFinished,
   output logic [1:0]  o_owner,
   output logic        o_busy,
   output logic        o_timeoutErr
);
   localparam logic [31:0] GAP_CLKS = 32'(guardBits * clksPerBit);
   localparam logic [31:0] TMO_LAST = 32'(timeoutClks - 1);

   typedef enum logic [1:0] {s_idle, s_start, s_waitDone, s_guard} state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  grant_q, grant_d;
   logic        start_q, start_d;
   logic [7:0]  bits_q, bits_d;
   logic [1:0]  owner_q, owner_d;
   logic        busy_q, busy_d;
   logic        tmo_q, tmo_d;

   logic [1:0]  win, idx;
   logic        found;

   // Search starts just after the last owner, so the last winner is served last.
   always_comb begin
      win   = owner_q;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = owner_q + 2'(k);
         if (!found && i_req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = '0;
      start_d = 1'b0;
      tmo_d   = 1'b0;
      bits_d  = bits_q;
      owner_d = owner_q;
      busy_d  = busy_q;
      case (state_q)
         s_idle: begin
            if (found && !i_txBusy) begin
               bits_d  = i_reqData[{win, 3'b000} +: 8];
               owner_d = win;
               grant_d = 4'b0001 << win;
               busy_d  = 1'b1;
               state_d = s_start;
            end
         end
         s_start: begin
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = s_waitDone;
         end
         s_waitDone: begin
            // A finish arriving on the timeout edge still counts as a clean frame.
            if (i_txFinished) begin
               cnt_d   = '0;
               state_d = s_guard;
            end else if (cnt_q == TMO_LAST) begin
               tmo_d   = 1'b1;
               cnt_d   = '0;
               state_d = s_guard;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         s_guard: begin
            if (GAP_CLKS == 32'd0 || cnt_q == GAP_CLKS - 32'd1) begin
               busy_d  = 1'b0;
               state_d = s_idle;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = s_idle;
      endcase
   end

   always_ff @(posedge i_clkTx) begin
      if (!i_rstN) begin
         state_q <= s_idle;
         cnt_q   <= '0;
         grant_q <= '0;
         start_q <= 1'b0;
         bits_q  <= 8'h00;
         owner_q <= 2'd3;
         busy_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         start_q <= start_d;
         bits_q  <= bits_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
         tmo_q   <= tmo_d;
      end
   end

   assign o_grant      = grant_q;
   assign o_txStart    = start_q;
   assign o_txBits     = bits_q;
   assign o_owner      = owner_q;
   assign o_busy       = busy_q;
   assign o_timeoutErr = tmo_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between four byte-oriented requesters. Each requester presents a byte with a request flag; the arbiter grants one, launches the transmitter with a start pulse, waits for frame completion (or a timeout), enforces an inter-frame guard gap, then serves the next requester. Sits between the on-chip byte sources and the UART TX datapath, mirroring the RX path on the other side of the link.

## Interface

- clksPerBit, default 87: clocks per UART bit, same value as the transmitter's.
- guardBits, default 1: idle bit periods inserted after each frame; gap = guardBits*clksPerBit clocks; 0 = no gap.
- timeoutClks, default 2048: max clocks waiting for i_txFinished after o_txStart before abandoning the frame; must exceed 12*clksPerBit.

- i_clkTx  in  1  clock, all logic on rising edge.
- i_rstN  in  1  synchronous, active-low reset.
- i_req  in  4  request flags; bit k = requester k has a byte pending.
- i_reqData  in  32  requester k byte on [8k+7:8k].
- o_grant  out  4  one-hot, one-cycle pulse: byte of requester k captured; requester may drop or change its request from the next cycle.
- o_txStart  out  1  one-cycle start pulse to transmitter.
- o_txBits  out  8  byte to transmit; stable from grant until back in idle.
- i_txBusy  in  1  transmitter busy; no grant issued while high.
- i_txFinished  in  1  one-cycle pulse from transmitter at end of stop bit.
- o_owner  out  2  index of current/last granted requester.
- o_busy  out  1  high from grant until return to idle.
- o_timeoutErr  out  1  one-cycle pulse when a frame times out.

## Operation

- States: s_idle, s_start, s_waitDone, s_guard (2-bit encoding, default branch -> s_idle).
- s_idle: if i_req != 0 and i_txBusy == 0: select winner, latch o_txBits <= its byte, o_owner <= winner, o_grant <= onehot(winner), o_busy <= 1, -> s_start. Otherwise hold, o_grant = 0.
- Round-robin: search order o_owner+1, +2, +3, +0 (mod 4); first set bit wins. Reset o_owner = 3, so after reset requester 0 has top priority.
- s_start: o_txStart <= 1 (single cycle), clear timeout counter, -> s_waitDone.
- s_waitDone: on i_txFinished -> s_guard (clear guard counter). Else if timeout counter == timeoutClks-1: o_timeoutErr <= 1 (single cycle), -> s_guard. Else increment counter.
- s_guard: count guardBits*clksPerBit clocks, then o_busy <= 0, -> s_idle. If guardBits == 0, leave s_guard after one clock.
- i_txFinished outside s_waitDone ignored. i_txBusy sampled only in s_idle.
- Counters: 32-bit; compare exact, no wrap reachable.

## Timing

- Reset (i_rstN low at an edge): o_grant 0, o_txStart 0, o_txBits 8'h00, o_owner 2'd3, o_busy 0, o_timeoutErr 0, state s_idle. Takes priority over everything; mid-frame reset abandons the frame without aborting the transmitter (transmitter completes; its i_txFinished is ignored).
- Request sampled at edge E (state s_idle): o_grant, o_txBits, o_owner, o_busy valid after E; o_txStart high for the cycle after E+1.
- Frame-to-frame minimum: grant, start, wait, guard; next grant no earlier than guardBits*clksPerBit+1 clocks after the i_txFinished edge.
- i_txFinished and timeout on the same edge: finished wins, no o_timeoutErr.
- Request dropped before grant: not served; no memory of past requests.
- All four requesting continuously: grants cycle 0,1,2,3,0...
- Request set on the same edge the arbiter returns to s_idle: eligible at the following edge.

## Test plan

Bench parameters: clksPerBit=4, guardBits=1, timeoutClks=64; transmitter model pulses i_txFinished 40 clocks after o_txStart.
- Reset then i_req=4'b0100, byte2=8'hA5 -> o_grant=4'b0100 one cycle, o_txBits=8'hA5, o_owner=2, o_txStart one cycle later, o_busy low 4 clocks after i_txFinished.
- i_req=4'b1111 held, bytes 8'h10/11/12/13 -> frames transmitted 10,11,12,13,10 in order; no two grants closer than 46 clocks.
- Transmitter never pulses i_txFinished -> o_timeoutErr single pulse 64 clocks after o_txStart, arbiter returns to idle and serves next request.
- i_txBusy=1 with i_req=4'b0001 -> no grant; grant on the edge after i_txBusy falls.
- i_txFinished on the timeout edge -> no o_timeoutErr, normal guard.
- i_rstN low during s_waitDone -> all outputs to reset values next edge, o_owner=3; later i_txFinished ignored; next grant goes to requester 0 when several request.
